// File: rtl/ccir656_rx_if.sv
// ccir656_rx_if: video-side bundle for the BT.656 receiver.
//   din                  : BT.656 byte stream, one byte per clk27M (source -> receiver)
//   cb, y0, cr, y1       : demultiplexed 4:2:2 pixel pair
//   pair_valid           : one-cycle strobe, pair fields valid
//   pair_cnt             : index of the emitted pair within the line
//   line_cnt             : line index within the current field (saturating)
//   field, vblank, hblank: F, V, H bits of the last valid timing code
//   sav_pulse, eav_pulse : one-cycle strobes on accepted SAV / EAV codes
//   xy_err, len_err      : one-cycle error strobes
//   locked               : EAV then SAV seen with no error since
// Modports: master = byte source / result consumer, slave = receiver.
interface ccir656_rx_if #(
  parameter int LINE_W = 10,
  parameter int PIX_W  = 10
) ();
  logic [7:0]        din;
  logic [7:0]        cb;
  logic [7:0]        y0;
  logic [7:0]        cr;
  logic [7:0]        y1;
  logic              pair_valid;
  logic [PIX_W-1:0]  pair_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              field;
  logic              vblank;
  logic              hblank;
  logic              sav_pulse;
  logic              eav_pulse;
  logic              xy_err;
  logic              len_err;
  logic              locked;

  modport master (
    output din,
    input  cb, y0, cr, y1, pair_valid, pair_cnt, line_cnt,
    input  field, vblank, hblank, sav_pulse, eav_pulse, xy_err, len_err, locked
  );

  modport slave (
    input  din,
    output cb, y0, cr, y1, pair_valid, pair_cnt, line_cnt,
    output field, vblank, hblank, sav_pulse, eav_pulse, xy_err, len_err, locked
  );
endinterface

// File: rtl/ccir656_rx.sv
// ccir656_rx: ITU-R BT.656 byte-stream receiver.
// Detects FF 00 00 XY timing reference codes, validates the XY protection
// bits, tracks field / vertical blank / horizontal blank and splits the
// active Cb Y0 Cr Y1 byte sequence into 4:2:2 pixel pairs.
// Ports:
//   clk27M : byte clock, one din byte per cycle
//   rst    : asynchronous active-high reset
//   vid    : ccir656_rx_if.slave (din in; pair data, counters, flags,
//            strobes and lock status out, all registered)
module ccir656_rx #(
  parameter int SAMPLES_PER_LINE = 1440,
  parameter int LINE_W           = 10,
  parameter int PIX_W            = 10
) (
  input logic         clk27M,
  input logic         rst,
  ccir656_rx_if.slave vid
);

  // Counter runs on through the 4-byte EAV that follows the active samples.
  localparam int CNT_W = $clog2(SAMPLES_PER_LINE + 4);
  localparam logic [CNT_W-1:0] SPL = CNT_W'(SAMPLES_PER_LINE);

  typedef enum logic [1:0] {SEARCH, BLANK, ACTIVE, WAIT_EAV} state_t;

  state_t            state, state_nx;
  logic [7:0]        din;
  logic [7:0]        hist_p1, hist_p2, hist_p3;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [1:0]        phase, phase_nx;
  logic [1:0]        wait_off;
  logic [7:0]        cb_q, y0_q, cr_q;
  logic              pre_hit, xy_ok, code_ok, code_bad, is_eav, is_sav;
  logic              cap_en, y1_byte, emit, len_err_nx;
  logic              last_eav;

  logic [7:0]        cb_r, y0_r, cr_r, y1_r;
  logic              pair_valid_r;
  logic [PIX_W-1:0]  pair_cnt_r;
  logic [LINE_W-1:0] line_cnt_r;
  logic              field_r, vblank_r, hblank_r;
  logic              sav_r, eav_r, xy_err_r, len_err_r, locked_r;

  // Expected P3..P0 for a given F, V, H.
  function automatic logic [3:0] xy_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [LINE_W-1:0] sat_inc(input logic [LINE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign din      = vid.din;
  assign pre_hit  = (hist_p3 == 8'hFF) && (hist_p2 == 8'h00) && (hist_p1 == 8'h00);
  assign xy_ok    = din[7] && (din[3:0] == xy_prot(din[6], din[5], din[4]));
  assign code_ok  = pre_hit && xy_ok;
  assign code_bad = pre_hit && !xy_ok;
  assign is_eav   = code_ok && din[4];
  assign is_sav   = code_ok && !din[4];
  // Position inside the trailing EAV: 0 = FF, 1/2 = 00, 3 = XY.
  assign wait_off = 2'(cnt - SPL);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    phase_nx   = phase;
    len_err_nx = 1'b0;
    cap_en     = 1'b0;
    y1_byte    = 1'b0;
    case (state)
      SEARCH: begin
        if (is_eav) state_nx = BLANK;
      end
      BLANK: begin
        if (is_sav) begin
          state_nx = ACTIVE;
          cnt_nx   = '0;
          phase_nx = '0;
        end
      end
      ACTIVE: begin
        // FF never occurs in active video, so it means the line ended early.
        if (din == 8'hFF) begin
          len_err_nx = 1'b1;
          state_nx   = SEARCH;
        end else begin
          cap_en   = 1'b1;
          y1_byte  = (phase == 2'd3);
          cnt_nx   = cnt + 1'b1;
          phase_nx = phase + 2'd1;
          if (cnt_nx == SPL) state_nx = WAIT_EAV;
        end
      end
      WAIT_EAV: begin
        cnt_nx = cnt + 1'b1;
        case (wait_off)
          2'd0: begin
            if (din != 8'hFF) begin
              len_err_nx = 1'b1;
              state_nx   = SEARCH;
            end
          end
          2'd1, 2'd2: begin
            if (din != 8'h00) begin
              len_err_nx = 1'b1;
              state_nx   = SEARCH;
            end
          end
          default: begin
            if (is_eav) begin
              state_nx = BLANK;
            end else if (is_sav) begin
              len_err_nx = 1'b1;
              state_nx   = SEARCH;
            end
          end
        endcase
      end
      default: state_nx = SEARCH;
    endcase
    if (code_bad) state_nx = SEARCH;
  end

  // A pair is only released on clean, locked, non-vblank lines.
  assign emit = y1_byte && locked_r && !vblank_r;

  // Byte capture; data path carries no reset.
  always_ff @(posedge clk27M) begin
    if (cap_en) begin
      case (phase)
        2'd0:    cb_q <= din;
        2'd1:    y0_q <= din;
        2'd2:    cr_q <= din;
        default: ;
      endcase
    end
  end

  // Output / control stage: everything seen one cycle after the byte.
  always_ff @(posedge clk27M or posedge rst) begin
    if (rst) begin
      state        <= SEARCH;
      hist_p1      <= '0;
      hist_p2      <= '0;
      hist_p3      <= '0;
      cnt          <= '0;
      phase        <= '0;
      last_eav     <= 1'b0;
      cb_r         <= '0;
      y0_r         <= '0;
      cr_r         <= '0;
      y1_r         <= '0;
      pair_valid_r <= 1'b0;
      pair_cnt_r   <= '0;
      line_cnt_r   <= '0;
      field_r      <= 1'b0;
      vblank_r     <= 1'b0;
      hblank_r     <= 1'b1;
      sav_r        <= 1'b0;
      eav_r        <= 1'b0;
      xy_err_r     <= 1'b0;
      len_err_r    <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      state        <= state_nx;
      hist_p1      <= din;
      hist_p2      <= hist_p1;
      hist_p3      <= hist_p2;
      cnt          <= cnt_nx;
      phase        <= phase_nx;
      pair_valid_r <= emit;
      sav_r        <= is_sav;
      eav_r        <= is_eav;
      xy_err_r     <= code_bad;
      len_err_r    <= len_err_nx;

      if (emit) begin
        cb_r <= cb_q;
        y0_r <= y0_q;
        cr_r <= cr_q;
        y1_r <= din;
      end

      // pair_cnt holds the index during the strobe and advances afterwards.
      if (is_sav)            pair_cnt_r <= '0;
      else if (pair_valid_r) pair_cnt_r <= pair_cnt_r + 1'b1;

      if (is_eav) begin
        if (din[6] != field_r) line_cnt_r <= '0;
        else                   line_cnt_r <= sat_inc(line_cnt_r);
      end

      if (code_ok) begin
        field_r  <= din[6];
        vblank_r <= din[5];
        hblank_r <= din[4];
      end

      // Any error forces a fresh EAV before the next SAV can lock.
      if (code_bad || len_err_nx) begin
        locked_r <= 1'b0;
        last_eav <= 1'b0;
      end else if (code_ok) begin
        if (is_sav && last_eav) locked_r <= 1'b1;
        last_eav <= din[4];
      end
    end
  end

  assign vid.cb         = cb_r;
  assign vid.y0         = y0_r;
  assign vid.cr         = cr_r;
  assign vid.y1         = y1_r;
  assign vid.pair_valid = pair_valid_r;
  assign vid.pair_cnt   = pair_cnt_r;
  assign vid.line_cnt   = line_cnt_r;
  assign vid.field      = field_r;
  assign vid.vblank     = vblank_r;
  assign vid.hblank     = hblank_r;
  assign vid.sav_pulse  = sav_r;
  assign vid.eav_pulse  = eav_r;
  assign vid.xy_err     = xy_err_r;
  assign vid.len_err    = len_err_r;
  assign vid.locked     = locked_r;

endmodule

// File: tb/tb_ccir656_rx.sv
// tb_ccir656_rx: self-checking bench for ccir656_rx.
// Drives BT.656 lines byte by byte; expected pixel pairs are queued as the
// Y1 byte is driven and compared when pair_valid appears.
`timescale 1ns/100ps
module tb_ccir656_rx;
  localparam int SPL    = 1440;
  localparam int LINE_W = 10;
  localparam int PIX_W  = 10;
  localparam logic [63:0] RST_OUTS = 64'h20;  // only hblank set

  logic clk27M = 1'b0;
  logic rst;
  always #18.5 clk27M = ~clk27M;

  ccir656_rx_if #(.LINE_W(LINE_W), .PIX_W(PIX_W)) vid ();

  ccir656_rx #(
    .SAMPLES_PER_LINE(SPL),
    .LINE_W(LINE_W),
    .PIX_W(PIX_W)
  ) dut (
    .clk27M(clk27M),
    .rst(rst),
    .vid(vid)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_pairs  = 0;
  int n_len    = 0;
  int n_xy     = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_w;

  logic              exp_field, exp_vb, exp_hb;
  logic [LINE_W-1:0] exp_line;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({vid.cb, vid.y0, vid.cr, vid.y1, vid.pair_valid, vid.pair_cnt, vid.line_cnt,
                vid.field, vid.vblank, vid.hblank, vid.sav_pulse, vid.eav_pulse,
                vid.xy_err, vid.len_err, vid.locked});
  endfunction

  // mode 0: constant 10,20,30,40; mode 1: per-pair ramp (never FF or 00).
  function automatic logic [31:0] pair_data(input int mode, input int p);
    logic [7:0] c, a, r, b;
    if (mode == 0) return 32'h10203040;
    c = 8'h40 + 8'(p % 64);
    a = 8'h80 + 8'(p % 100);
    r = 8'h20 + 8'(p % 32);
    b = 8'hC0 - 8'(p % 128);
    return {c, a, r, b};
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk27M) begin
    if (!rst) begin
      if (vid.len_err) n_len++;
      if (vid.xy_err)  n_xy++;
      if (vid.pair_valid) begin
        n_pairs++;
        if (exp_q.size() == 0) begin
          check("pair_unexpected", 64'(vid.pair_cnt), 64'hFFFF);
        end else begin
          exp_w = exp_q.pop_front();
          check("pair", 64'({vid.cb, vid.y0, vid.cr, vid.y1, vid.pair_cnt}), exp_w);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk27M);
    vid.din = b;
  endtask

  task automatic settle();
    @(posedge clk27M);
    #1;
  endtask

  task automatic send_blank(input int n);
    for (int k = 0; k < n; k++) send_byte((k % 2) ? 8'h10 : 8'h80);
  endtask

  task automatic send_active(input int n, input int mode, input bit emit);
    logic [31:0] pd;
    for (int k = 0; k < n; k++) begin
      pd = pair_data(mode, k / 4);
      case (k % 4)
        0:       send_byte(pd[31:24]);
        1:       send_byte(pd[23:16]);
        2:       send_byte(pd[15:8]);
        default: send_byte(pd[7:0]);
      endcase
      if (emit && (k % 4 == 3)) exp_q.push_back(64'({pd, PIX_W'(k / 4)}));
    end
  endtask

  // Drive the XY byte and check the decoder response one cycle later.
  task automatic code_tail(input logic [7:0] xy, input bit ok);
    send_byte(xy);
    settle();
    if (ok) begin
      if (xy[4]) begin
        if (xy[6] != exp_field) exp_line = '0;
        else if (exp_line != '1) exp_line = exp_line + 1'b1;
        check("eav_pulse", 64'(vid.eav_pulse), 64'd1);
        check("line_cnt", 64'(vid.line_cnt), 64'(exp_line));
      end else begin
        check("sav_pulse", 64'(vid.sav_pulse), 64'd1);
        check("sav_pair_cnt", 64'(vid.pair_cnt), 64'd0);
      end
      exp_field = xy[6];
      exp_vb    = xy[5];
      exp_hb    = xy[4];
      check("flags", 64'({vid.field, vid.vblank, vid.hblank}), 64'({exp_field, exp_vb, exp_hb}));
    end else begin
      check("xy_err", 64'(vid.xy_err), 64'd1);
      check("flags_hold", 64'({vid.field, vid.vblank, vid.hblank}), 64'({exp_field, exp_vb, exp_hb}));
    end
  endtask

  task automatic send_code(input logic [7:0] xy, input bit ok);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    code_tail(xy, ok);
  endtask

  task automatic send_line(input logic [7:0] sav, input int n, input int mode,
                           input bit emit, input logic [7:0] eav);
    send_blank(276);
    send_code(sav, 1'b1);
    send_active(n, mode, emit);
    send_code(eav, 1'b1);
  endtask

  int p0, l0, x0;

  initial begin
    vid.din   = 8'h00;
    rst       = 1'b1;
    exp_field = 1'b0;
    exp_vb    = 1'b0;
    exp_hb    = 1'b1;
    exp_line  = '0;
    repeat (3) @(posedge clk27M);
    #1;
    check("reset_outs", outs(), RST_OUTS);
    @(negedge clk27M);
    rst = 1'b0;

    // Vertical-blank line (B6/AB): locks but emits nothing.
    send_blank(20);
    send_code(8'hB6, 1'b1);
    check("lock_before_sav", 64'(vid.locked), 64'd0);
    send_blank(276);
    send_code(8'hAB, 1'b1);
    check("lock_after_sav", 64'(vid.locked), 64'd1);
    p0 = n_pairs;
    send_active(SPL, 0, 1'b0);
    send_code(8'h9D, 1'b1);
    check("vblank_pairs", 64'(n_pairs - p0), 64'd0);

    // Nominal active line, 10,20,30,40.
    p0 = n_pairs;
    send_line(8'h80, SPL, 0, 1'b1, 8'h9D);
    check("nominal_pairs", 64'(n_pairs - p0), 64'd360);
    check("nominal_lock", 64'(vid.locked), 64'd1);

    // Protection error in place of SAV.
    send_blank(276);
    x0 = n_xy;
    send_code(8'hAC, 1'b0);
    check("xy_unlock", 64'(vid.locked), 64'd0);
    p0 = n_pairs;
    send_active(SPL, 1, 1'b0);
    send_code(8'h9D, 1'b1);
    check("xy_no_pairs", 64'(n_pairs - p0), 64'd0);
    check("xy_count", 64'(n_xy - x0), 64'd1);
    send_line(8'h80, SPL, 1, 1'b1, 8'h9D);
    check("xy_relock", 64'(vid.locked), 64'd1);

    // Field change: three F1 EAVs then 9D.
    p0 = n_pairs;
    send_line(8'h80, SPL, 1, 1'b1, 8'hF1);
    check("f1_line0", 64'(vid.line_cnt), 64'd0);
    send_line(8'hEC, SPL, 1, 1'b0, 8'hF1);
    check("f1_line1", 64'(vid.line_cnt), 64'd1);
    send_line(8'hEC, SPL, 1, 1'b0, 8'hF1);
    check("f1_line2", 64'(vid.line_cnt), 64'd2);
    send_line(8'hEC, SPL, 1, 1'b0, 8'h9D);
    check("f0_line0", 64'(vid.line_cnt), 64'd0);
    check("field_pairs", 64'(n_pairs - p0), 64'd360);

    // Short line: FF at sample 800.
    send_blank(276);
    send_code(8'h80, 1'b1);
    l0 = n_len;
    p0 = n_pairs;
    send_active(800, 1, 1'b1);
    send_byte(8'hFF);
    settle();
    check("short_len_err", 64'(vid.len_err), 64'd1);
    check("short_unlock", 64'(vid.locked), 64'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    code_tail(8'h9D, 1'b1);
    check("short_pairs", 64'(n_pairs - p0), 64'd200);
    check("short_len_count", 64'(n_len - l0), 64'd1);
    send_line(8'h80, SPL, 0, 1'b1, 8'h9D);
    check("short_relock", 64'(vid.locked), 64'd1);

    // Long line: 1444 active bytes.
    send_blank(276);
    send_code(8'h80, 1'b1);
    l0 = n_len;
    send_active(SPL, 1, 1'b1);
    send_byte(8'h10);
    settle();
    check("long_len_err", 64'(vid.len_err), 64'd1);
    check("long_unlock", 64'(vid.locked), 64'd0);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    send_code(8'h9D, 1'b1);
    check("long_len_count", 64'(n_len - l0), 64'd1);
    send_line(8'h80, SPL, 1, 1'b1, 8'h9D);
    check("long_relock", 64'(vid.locked), 64'd1);

    // Asynchronous reset in mid-line.
    send_blank(276);
    send_code(8'h80, 1'b1);
    send_active(401, 1, 1'b1);
    settle();
    #2;
    rst = 1'b1;
    #1;
    check("midline_reset_outs", outs(), RST_OUTS);
    exp_field = 1'b0;
    exp_vb    = 1'b0;
    exp_hb    = 1'b1;
    exp_line  = '0;
    repeat (3) @(posedge clk27M);
    @(negedge clk27M);
    rst = 1'b0;
    p0 = n_pairs;
    send_active(SPL - 401, 1, 1'b0);
    send_code(8'h80, 1'b1);
    check("sav_only_no_lock", 64'(vid.locked), 64'd0);
    send_active(SPL, 1, 1'b0);
    send_code(8'h9D, 1'b1);
    check("post_reset_no_pairs", 64'(n_pairs - p0), 64'd0);
    send_line(8'h80, SPL, 0, 1'b1, 8'h9D);
    check("post_reset_lock", 64'(vid.locked), 64'd1);
    check("post_reset_pairs", 64'(n_pairs - p0), 64'd360);

    repeat (4) @(negedge clk27M);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("total_xy_err", 64'(n_xy), 64'd1);
    check("total_len_err", 64'(n_len), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
